period_log_sched: RTL and testbench



---
 rtl/period_log_sched.sv | 159 +++++++++++++++
 tb/tb_period_log_sched.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_log_sched.sv
// Round-robin scheduler sharing one log record port between N_CH period meters, with per-channel silence watchdogs.
// Optional build macro PERIOD_LOG_OVR_CNT_EN adds saturating per-channel overrun counters on ovr_cnt.
module period_log_sched #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LOG_W      = CH_W + 2 + CNT_W
) (
  input  logic                   cam_clk,
  input  logic                   cam_resetn,
  input  logic                   enable,
  input  logic [N_CH*CNT_W-1:0]  ch_period,
  input  logic [N_CH-1:0]        ch_new,
  output logic                   log_valid,
  input  logic                   log_ready,
  output logic [LOG_W-1:0]       log_data,
  input  logic                   clr_stats,
  output logic [N_CH*8-1:0]      ovr_cnt
);

  // state  | meaning
  // IDLE   | port free, grant the next pending slot if any
  // PRESENT| record on log_data, waiting for log_ready
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [0:0]       state;
  logic [CH_W-1:0]  last_grant;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  ovr;
  logic [N_CH-1:0]  tmo;
  logic [CNT_W-1:0] val [N_CH];
  logic [WD_W-1:0]  wd  [N_CH];

  logic             gnt_any;
  logic [CH_W-1:0]  gnt_id;
  logic [N_CH-1:0]  gnt_vec;
  logic [N_CH-1:0]  overwrite;
  int               sel;

  // Search upward from the channel after the last grant; disabled ports grant nothing.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    gnt_vec = '0;
    sel     = 0;
    if (state == IDLE && enable) begin
      for (int k = 1; k <= N_CH; k++) begin
        sel = (int'(last_grant) + k) % N_CH;
        if (!gnt_any && pend[sel]) begin
          gnt_any = 1'b1;
          gnt_id  = CH_W'(sel);
        end
      end
    end
    if (gnt_any) gnt_vec[gnt_id] = 1'b1;
  end

  assign overwrite = {N_CH{enable}} & ch_new & pend & ~gnt_vec;

  always_ff @(posedge cam_clk) begin
    if (!cam_resetn) begin
      pend <= '0;
      ovr  <= '0;
      tmo  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        val[i] <= '0;
        wd[i]  <= '0;
      end
    end else if (!enable) begin
      pend <= '0;
      ovr  <= '0;
      tmo  <= '0;
      for (int i = 0; i < N_CH; i++) wd[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_new[i]) begin
          // A fresh value always beats a timeout landing in the same cycle.
          val[i]  <= ch_period[i*CNT_W +: CNT_W];
          pend[i] <= 1'b1;
          tmo[i]  <= 1'b0;
          ovr[i]  <= overwrite[i];
          wd[i]   <= '0;
        end else begin
          if (gnt_vec[i]) begin
            pend[i] <= 1'b0;
            ovr[i]  <= 1'b0;
            tmo[i]  <= 1'b0;
          end
          if (TIMEOUT_CYC > 0) begin
            if (wd[i] == WD_W'(TIMEOUT_CYC - 1)) begin
              wd[i] <= '0;
              if (!pend[i]) begin
                pend[i] <= 1'b1;
                tmo[i]  <= 1'b1;
                val[i]  <= '1;
              end
            end else begin
              wd[i] <= wd[i] + WD_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge cam_clk) begin
    if (!cam_resetn) begin
      state      <= IDLE;
      log_valid  <= 1'b0;
      log_data   <= '0;
      last_grant <= CH_W'(N_CH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            log_data   <= {gnt_id, tmo[gnt_id], ovr[gnt_id], val[gnt_id]};
            log_valid  <= 1'b1;
            last_grant <= gnt_id;
            state      <= PRESENT;
          end
        end
        PRESENT: begin
          if (log_ready) begin
            log_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          log_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef PERIOD_LOG_OVR_CNT_EN
  always_ff @(posedge cam_clk) begin
    if (!cam_resetn) begin
      ovr_cnt <= '0;
    end else if (clr_stats) begin
      ovr_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (overwrite[i] && ovr_cnt[i*8 +: 8] != 8'hFF)
          ovr_cnt[i*8 +: 8] <= ovr_cnt[i*8 +: 8] + 8'd1;
      end
    end
  end
`else
  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats;
  assign ovr_cnt = '0;
`endif

endmodule

// File: tb/tb_period_log_sched.sv
// Bench for period_log_sched: directed scenarios plus random traffic, all checked against a slot-level reference model.
module tb_period_log_sched;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int TMO = 1000;

  logic            cam_clk = 1'b0;
  logic            cam_resetn;
  logic            enable;
  logic [N*W-1:0]  ch_period;
  logic [N-1:0]    ch_new;
  logic            log_valid;
  logic            log_ready;
  logic [35:0]     log_data;
  logic            clr_stats;
  logic [N*8-1:0]  ovr_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  period_log_sched #(.N_CH(N), .CNT_W(W), .TIMEOUT_CYC(TMO)) dut (
    .cam_clk(cam_clk), .cam_resetn(cam_resetn), .enable(enable),
    .ch_period(ch_period), .ch_new(ch_new), .log_valid(log_valid),
    .log_ready(log_ready), .log_data(log_data), .clr_stats(clr_stats),
    .ovr_cnt(ovr_cnt)
  );

  always #5 cam_clk = ~cam_clk;
  always @(posedge cam_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model: slots, a busy port and silence counts ----------------
  bit        m_on = 0;
  bit        m_busy;
  bit [35:0] m_rec;
  int        m_last;
  bit        m_pend [N];
  bit        m_ovr  [N];
  bit        m_tmo  [N];
  bit [31:0] m_val  [N];
  int        m_quiet[N];
  int        m_cnt  [N];
  bit        m_old  [N];
  int        m_gi;

  always @(posedge cam_clk) begin
    if (!cam_resetn) begin
      m_on = 1; m_busy = 0; m_rec = '0; m_last = N - 1;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_ovr[i] = 0; m_tmo[i] = 0; m_val[i] = '0;
        m_quiet[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) m_old[i] = m_pend[i];
      m_gi = -1;
      if (!m_busy && enable)
        for (int k = 1; k <= N; k++)
          if (m_gi < 0 && m_old[(m_last + k) % N]) m_gi = (m_last + k) % N;
      if (m_gi >= 0) begin
        m_rec  = {2'(m_gi), m_tmo[m_gi], m_ovr[m_gi], m_val[m_gi]};
        m_busy = 1;
        m_last = m_gi;
      end else if (m_busy && log_ready) begin
        m_busy = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (!enable) begin
          m_pend[i] = 0; m_ovr[i] = 0; m_tmo[i] = 0; m_quiet[i] = 0;
        end else if (ch_new[i]) begin
          m_ovr[i] = m_old[i] && (m_gi != i);
          if (m_ovr[i] && m_cnt[i] < 255) m_cnt[i]++;
          m_val[i] = ch_period[i*W +: W];
          m_pend[i] = 1; m_tmo[i] = 0; m_quiet[i] = 0;
        end else begin
          if (m_gi == i) begin m_pend[i] = 0; m_ovr[i] = 0; m_tmo[i] = 0; end
          m_quiet[i]++;
          if (m_quiet[i] == TMO) begin
            m_quiet[i] = 0;
            if (!m_old[i]) begin m_pend[i] = 1; m_tmo[i] = 1; m_val[i] = '1; end
          end
        end
      end
`ifdef PERIOD_LOG_OVR_CNT_EN
      if (clr_stats) for (int i = 0; i < N; i++) m_cnt[i] = 0;
`else
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
    end
  end

  function automatic logic [N*8-1:0] exp_cnt();
    logic [N*8-1:0] e;
    for (int i = 0; i < N; i++) e[i*8 +: 8] = 8'(m_cnt[i]);
    return e;
  endfunction

  always @(negedge cam_clk) begin
    if (m_on) begin
      chk("mdl_valid", 64'(log_valid), 64'(m_busy));
      chk("mdl_data", 64'(log_data), 64'(m_rec));
      chk("mdl_ovr_cnt", 64'(ovr_cnt), 64'(exp_cnt()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge cam_clk); #2; end
  endtask

  task automatic pulse(input int ch, input logic [31:0] v);
    ch_period[ch*W +: W] = v;
    ch_new[ch] = 1'b1;
    tick(1);
    ch_new = '0;
  endtask

  task automatic do_reset();
    @(negedge cam_clk);
    cam_resetn = 1'b0; ch_new = '1; enable = 1'b1; log_ready = 1'b1; clr_stats = 1'b0;
    repeat (3) @(negedge cam_clk);
    chk("rst_valid", 64'(log_valid), 64'd0);
    chk("rst_data", 64'(log_data), 64'd0);
    chk("rst_ovr_cnt", 64'(ovr_cnt), 64'd0);
    cam_resetn = 1'b1; ch_new = '0;
  endtask

  function automatic logic [35:0] rec(input int ch, input logic [1:0] fl, input logic [31:0] v);
    return {2'(ch), fl, v};
  endfunction

  function automatic logic [7:0] exp_ovr8(input int n);
`ifdef PERIOD_LOG_OVR_CNT_EN
    return 8'(n);
`else
    return 8'(n * 0);
`endif
  endfunction

  task automatic wait_rec(input int ch, input int budget, output int at, output logic [35:0] d);
    bit hit = 0;
    at = -1; d = '0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge cam_clk);
      if (log_valid && int'(log_data[35:34]) == ch) begin hit = 1; at = cyc; d = log_data; end
    end
    chk("wait_rec_found", 64'(hit), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  int cnt_v;
  int t0, t1, t2;
  logic [35:0] d;
  int exp_ch [3];

  initial begin
    cam_resetn = 1'b0; enable = 1'b1; ch_new = '0; ch_period = '0;
    log_ready = 1'b1; clr_stats = 1'b0;

    // Reset, then silence
    do_reset();
    cnt_v = 0;
    repeat (20) begin @(negedge cam_clk); if (log_valid) cnt_v++; end
    chk("post_rst_quiet", 64'(cnt_v), 64'd0);

    // Single update on ch1: visible exactly two edges after capture window
    tick(1);
    pulse(1, 32'h0000_1234);
    @(negedge cam_clk); chk("single_t1_valid", 64'(log_valid), 64'd0);
    @(negedge cam_clk); chk("single_t2_valid", 64'(log_valid), 64'd1);
    chk("single_data", 64'(log_data), 64'(rec(1, 2'b00, 32'h0000_1234)));
    @(negedge cam_clk); chk("single_t3_valid", 64'(log_valid), 64'd0);

    // Round-robin after a ch1 grant
    tick(1);
    ch_period[0*W +: W] = 32'hA0; ch_period[2*W +: W] = 32'hA2; ch_period[3*W +: W] = 32'hA3;
    ch_new = 4'b1101;
    tick(1);
    ch_new = '0;
    exp_ch[0] = 2; exp_ch[1] = 3; exp_ch[2] = 0;
    @(negedge cam_clk);
    for (int r = 0; r < 3; r++) begin
      @(negedge cam_clk);
      chk("rr_valid", 64'(log_valid), 64'd1);
      chk("rr_data", 64'(log_data), 64'(rec(exp_ch[r], 2'b00, 32'hA0 + 32'(exp_ch[r]))));
      @(negedge cam_clk);
      chk("rr_gap", 64'(log_valid), 64'd0);
    end

    // Backpressure and overrun on ch2
    do_reset();
    log_ready = 1'b0;
    tick(1);
    pulse(2, 32'h10);
    tick(3);
    pulse(2, 32'h20);
    pulse(2, 32'h30);
    @(negedge cam_clk);
    chk("bp_hold_valid", 64'(log_valid), 64'd1);
    chk("bp_hold_data", 64'(log_data), 64'(rec(2, 2'b00, 32'h10)));
    chk("bp_ovr_cnt", 64'(ovr_cnt[2*8 +: 8]), 64'(exp_ovr8(1)));
    log_ready = 1'b1;
    @(negedge cam_clk); chk("bp_accept", 64'(log_valid), 64'd0);
    @(negedge cam_clk);
    chk("bp_second_valid", 64'(log_valid), 64'd1);
    chk("bp_second_data", 64'(log_data), 64'(rec(2, 2'b01, 32'h30)));
    clr_stats = 1'b1;
    @(negedge cam_clk); clr_stats = 1'b0;
    @(negedge cam_clk); chk("bp_clr", 64'(ovr_cnt), 64'd0);

    // Timeout cadence on ch3, other channels offset by 500 cycles
    do_reset();
    tick(1);
    ch_new = 4'b0111; tick(1); ch_new = '0;
    tick(500);
    pulse(3, 32'h77);
    wait_rec(3, 10, t0, d);
    chk("tmo_strobe_data", 64'(d), 64'(rec(3, 2'b00, 32'h77)));
    wait_rec(3, 1100, t1, d);
    chk("tmo_first_data", 64'(d), 64'(rec(3, 2'b10, 32'hFFFF_FFFF)));
    chk("tmo_first_gap", 64'(t1 - t0), 64'd1000);
    wait_rec(3, 1100, t2, d);
    chk("tmo_repeat_data", 64'(d), 64'(rec(3, 2'b10, 32'hFFFF_FFFF)));
    chk("tmo_repeat_gap", 64'(t2 - t1), 64'd1000);
    tick(300);
    pulse(3, 32'h99);
    wait_rec(3, 10, t0, d);
    chk("tmo_restart_data", 64'(d), 64'(rec(3, 2'b00, 32'h99)));
    wait_rec(3, 1100, t1, d);
    chk("tmo_restart_gap", 64'(t1 - t0), 64'd1000);

    // Enable drop with a held record
    do_reset();
    log_ready = 1'b0;
    tick(1);
    pulse(0, 32'hA);
    tick(2);
    enable = 1'b0;
    ch_new = '1; tick(3); ch_new = '0;
    @(negedge cam_clk);
    chk("en_held_valid", 64'(log_valid), 64'd1);
    chk("en_held_data", 64'(log_data), 64'(rec(0, 2'b00, 32'hA)));
    log_ready = 1'b1;
    @(negedge cam_clk);
    @(negedge cam_clk); chk("en_drained", 64'(log_valid), 64'd0);
    cnt_v = 0;
    repeat (1500) begin @(negedge cam_clk); if (log_valid) cnt_v++; end
    chk("en_off_quiet", 64'(cnt_v), 64'd0);
    enable = 1'b1;

    // Random traffic; ch3 stays silent so its watchdog keeps firing
    do_reset();
    tick(1);
    repeat (4000) begin
      for (int i = 0; i < 3; i++) begin
        ch_new[i] = ($urandom_range(0, 5) == 0);
        ch_period[i*W +: W] = $urandom;
      end
      log_ready = ($urandom_range(0, 3) != 0);
      clr_stats = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      tick(1);
    end
    ch_new = '0; clr_stats = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
